uart_rx_mmio: RTL
=================

Name: uart_rx_mmio

Overview:
- 8N1 UART receiver. It is the receive-direction counterpart of the existing uart transmitter.
- Deserialises the board RX pin into bytes and buffers them in a small show-ahead FIFO.
- The CPU data path reads it through a memory-mapped load port, the same way it reads the hardware counter.
- Sits beside the transmitter in top. `rd_en` is driven from the data_ram load decode of the UART RX address.

Parameters:
- CLKS_PER_BIT, 868: sysclk cycles per bit (100 MHz / 115200). Minimum 4.
- FIFO_DEPTH, 4: receive buffer entries. Must be a power of 2.

Ports:
- CLK  input  1  system clock. All logic is on the rising edge.
- RST  input  1  synchronous, active-high reset.
- uart_rx  input  1  asynchronous serial line. Idle level is high.
- rd_en  input  1  pops the FIFO head this cycle. Ignored when the FIFO is empty.
- rd_data  output  8  FIFO head byte (show-ahead). 0x00 when empty.
- rx_valid  output  1  FIFO not empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes held.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.
- frame_err  output  1  sticky: a stop bit was sampled low.
- clr_err  input  1  clears `overrun` and `frame_err`.

Behaviour:
- Input synchroniser
  - Two-flop synchroniser on `uart_rx`, reset to 1.
  - All decisions below use the synchronised signal `rxs`.
- Reset
  - state=IDLE, FIFO empty, fifo_count=0, rx_valid=0, rd_data=0, overrun=0, frame_err=0, armed=0.
  - Reset mid-frame aborts the frame; partial bits are discarded.
- Arming
  - After reset, `armed` sets only once rxs=1 has been seen.
  - This prevents a mid-frame low level after reset being taken as a start bit.
- FSM (bit counter counts 0..CLKS_PER_BIT-1)
  - IDLE: if armed and rxs=0, go to START and clear the counter.
  - START: at count CLKS_PER_BIT/2-1 (mid start bit):
    - rxs=0: go to DATA, clear counter, bit index=0.
    - rxs=1: glitch; go back to IDLE with no other effect.
  - DATA: at each count CLKS_PER_BIT-1, shift rxs in LSB-first. After bit index 7, go to STOP.
  - STOP: at count CLKS_PER_BIT-1 (mid stop bit), then return to IDLE in the same cycle:
    - rxs=1: push the byte.
    - rxs=0: set frame_err and discard the byte.
  - Returning to IDLE at mid stop bit means back-to-back frames with no idle gap are received.
- FIFO
  - Circular buffer with read and write pointers of width log2(DEPTH), plus a count register.
  - A pushed byte appears on rd_data/rx_valid/fifo_count the cycle after the stop sample, if the FIFO was empty.
  - Otherwise the head is unchanged and only fifo_count increments.
  - rd_en with FIFO non-empty: head advances next cycle and count decrements.
  - Push while full without a simultaneous pop: byte dropped, overrun=1, contents unchanged.
  - Push and pop in the same cycle while full: both happen, count stays DEPTH, no overrun.
  - Push and pop in the same cycle while non-full and non-empty: count unchanged.
  - Pointers wrap modulo DEPTH.
- Error flags
  - Sticky until clr_err.
  - clr_err in the same cycle as a new error event: the set wins.
- Latency
  - Line falling edge to START: 3 cycles (2 synchroniser + 1).
  - Start edge to byte visible: about 9.5 × CLKS_PER_BIT + 3 cycles.
  - Bench tolerance: ±2 cycles.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4; line held high ≥20 cycles after reset):
- Single byte: send 0x55 → rx_valid=1, rd_data=0x55, fifo_count=1. One cycle of rd_en → rx_valid=0, fifo_count=0, rd_data=0x00.
- Fill and overrun: send 0xA3, 0x00, 0xFF, 0x81 back-to-back with no idle gap → fifo_count=4. Send 0x7E → overrun=1, fifo_count=4. Four pops return A3, 00, FF, 81 in order. clr_err → overrun=0.
- Glitch: line low for 5 cycles, then high → no push, fifo_count=0. Then send 0x3C → received as 0x3C.
- Framing error: send 0x12 with the stop bit low → frame_err=1, fifo_count unchanged. Line high, send 0x34 → received, frame_err stays 1. clr_err with no new error → frame_err=0.
- Reset mid-frame: assert RST after 3 data bits of 0xC5, keep the line low for 40 more cycles → no push, no frame_err, fifo_count=0. Line high, send 0x5A → rd_data=0x5A.
- Full simultaneous pop/push: with the FIFO full, assert rd_en in the stop-sample cycle of byte 0x99 → overrun=0, fifo_count=4, 0x99 is the last entry read.

Source files
------------

// File: rtl/uart_rx_mmio_if.sv
// Load-port bundle between the CPU data path and the UART receiver.
// The master is the CPU side; the slave is the receiver.
interface uart_rx_mmio_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic            rd_en;
    logic [7:0]      rd_data;
    logic            rx_valid;
    logic [CntW-1:0] fifo_count;
    logic            overrun;
    logic            frame_err;
    logic            clr_err;

    modport master (
        output rd_en,
        output clr_err,
        input  rd_data,
        input  rx_valid,
        input  fifo_count,
        input  overrun,
        input  frame_err
    );

    modport slave (
        input  rd_en,
        input  clr_err,
        output rd_data,
        output rx_valid,
        output fifo_count,
        output overrun,
        output frame_err
    );
endinterface

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver with a show-ahead receive FIFO read through a memory-mapped load port.
// Sticky overrun / framing-error flags are cleared by clr_err.
module uart_rx_mmio #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          uart_rx,
    uart_rx_mmio_if.slave mmio
);
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FcW  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [PtrW-1:0] PtrLast  = PtrW'(FIFO_DEPTH - 1);
    localparam logic [FcW-1:0]  FullCnt  = FcW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [1:0]      warm_q, warm_d;
    logic            armed_q, armed_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FcW-1:0]  count_q, count_d;
    logic            overrun_q, overrun_d;
    logic            frame_err_q, frame_err_d;

    logic rxs;
    logic push, frame_set;
    logic pop, full, do_push;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + PtrW'(1);
    endfunction

    assign rxs = sync_q[1];

    // The synchroniser resets high, so arming waits until sync_q holds two real line samples.
    always_comb begin
        sync_d  = {sync_q[0], uart_rx};
        warm_d  = {warm_q[0], 1'b1};
        armed_d = armed_q | (warm_q[1] & rxs);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (armed_q && !rxs) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    if (!rxs) begin
                        state_d   = StData;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    shift_d   = {rxs, shift_q[7:1]};
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                // Leave at mid stop bit so a start bit right after the stop bit is caught.
                if (cnt_q == BitLast) begin
                    state_d   = StIdle;
                    push      = rxs;
                    frame_set = ~rxs;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pop      = mmio.rd_en && (count_q != '0);
        full     = (count_q == FullCnt);
        do_push  = push && (!full || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !pop) begin
            count_d = count_q + FcW'(1);
        end else if (pop && !do_push) begin
            count_d = count_q - FcW'(1);
        end
        // A new error event outranks a simultaneous clear.
        overrun_d   = (overrun_q && !mmio.clr_err) || (push && full && !pop);
        frame_err_d = (frame_err_q && !mmio.clr_err) || frame_set;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            sync_q      <= 2'b11;
            warm_q      <= 2'b00;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            warm_q      <= warm_d;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign mmio.rd_data    = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign mmio.rx_valid   = (count_q != '0);
    assign mmio.fifo_count = count_q;
    assign mmio.overrun    = overrun_q;
    assign mmio.frame_err  = frame_err_q;
endmodule
